// File: rtl/prot_pal_pkg.sv
// Shared types for the programmable PAL protection emulator: table entry layout,
// field widths and the power-on match table.
package prot_pal_pkg;

    localparam int unsigned PAL_DW    = 8;
    localparam int unsigned PAL_OW    = 8;
    localparam int unsigned PAL_MODES = 2;
    localparam int unsigned PAL_MW    = $clog2(PAL_MODES);
    localparam int unsigned PAL_DEF_N = 8;

    typedef struct packed {
        logic              valid;
        logic [PAL_DW-1:0] key;
        logic [PAL_DW-1:0] mask;
        logic [PAL_MW-1:0] mode;
        logic              any;
        logic              set;
        logic [PAL_MW-1:0] next;
        logic [PAL_OW-1:0] resp;
    } pal_entry_t;

    // Field order: valid, key, mask, mode, any, set, next, resp
    localparam pal_entry_t DEFAULT_TABLE [PAL_DEF_N] = '{
        '{1'b1, 8'ha5, 8'hff, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40},
        '{1'b1, 8'hcd, 8'hff, 1'b0, 1'b1, 1'b1, 1'b0, 8'h16},
        '{1'b1, 8'hc2, 8'hff, 1'b0, 1'b1, 1'b1, 1'b1, 8'h4c},
        '{1'b1, 8'h36, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7a},
        '{1'b1, 8'h36, 8'hff, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2a},
        '{1'b1, 8'h6f, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3e},
        '{1'b1, 8'h6f, 8'hff, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66},
        '{1'b0, 8'h00, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}
    };

    function automatic pal_entry_t default_entry(input int idx);
        pal_entry_t e;
        e = '0;
        if (idx >= 0 && idx < int'(PAL_DEF_N)) begin
            e = DEFAULT_TABLE[idx[2:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/prot_pal_match.sv
// Combinational priority matcher: the lowest-index valid entry whose care bits
// equal the sampled data and whose mode qualifies wins.
module prot_pal_match
    import prot_pal_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned AW      = $clog2(ENTRIES)
) (
    input  pal_entry_t        tbl [ENTRIES],
    input  logic [PAL_DW-1:0] din,
    input  logic [PAL_MW-1:0] mode,
    output logic              hit,
    output logic [AW-1:0]     idx,
    output pal_entry_t        ent
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        ent = '0;
        // Scan downwards so the lowest matching index is the last one kept
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (tbl[i].valid && (((din ^ tbl[i].key) & tbl[i].mask) == '0) &&
                (tbl[i].any || (tbl[i].mode == mode))) begin
                hit = 1'b1;
                idx = AW'(i);
                ent = tbl[i];
            end
        end
    end

endmodule

// File: rtl/prot_pal_seq.sv
// Run-time programmable registered-PAL protection emulator (top). Define
// PROT_PAL_MASK_EN to store and honour per-entry care masks; otherwise exact match.
module prot_pal_seq
    import prot_pal_pkg::*;
#(
    // Widths must agree with the entry layout in prot_pal_pkg
    parameter int unsigned DW       = PAL_DW,
    parameter int unsigned OW       = PAL_OW,
    parameter int unsigned ENTRIES  = 8,
    parameter int unsigned MODES    = PAL_MODES,
    parameter logic [OW-1:0] OUT_MASK = 8'h7e,
    localparam int unsigned MW      = $clog2(MODES),
    localparam int unsigned AW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_n,
    input  logic          gate,
    input  logic [DW-1:0] din,
    output logic [OW-1:0] dout,
    output logic [MW-1:0] mode,
    output logic [7:0]    hit_cnt,
    output logic          miss,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_key,
    input  logic [DW-1:0] cfg_mask,
    input  logic [OW-1:0] cfg_resp,
    input  logic [MW-1:0] cfg_mode,
    input  logic          cfg_any,
    input  logic          cfg_set,
    input  logic [MW-1:0] cfg_next,
    input  logic          cfg_valid
);

    logic          wr_q;
    logic          ev_q;
    logic [DW-1:0] din_q;
    logic [OW-1:0] resp_q;
    logic [MW-1:0] mode_q;
    logic [7:0]    hit_cnt_q;
    logic          miss_q;
    pal_entry_t    tbl_q [ENTRIES];

    logic          event_d;
    pal_entry_t    cfg_ent;
    logic          hit;
    logic [AW-1:0] unused_hit_idx;
    pal_entry_t    hit_ent;

    assign event_d = wr_q & ~wr_n & gate;

    always_comb begin
        cfg_ent       = '0;
        cfg_ent.valid = cfg_valid;
        cfg_ent.key   = cfg_key;
`ifdef PROT_PAL_MASK_EN
        cfg_ent.mask  = cfg_mask;
`else
        // Mask bits stay at all-ones so they reduce to constants
        cfg_ent.mask  = '1;
`endif
        cfg_ent.mode  = cfg_mode;
        cfg_ent.any   = cfg_any;
        cfg_ent.set   = cfg_set;
        cfg_ent.next  = cfg_next;
        cfg_ent.resp  = cfg_resp;
    end

`ifndef PROT_PAL_MASK_EN
    logic unused_cfg_mask;
    assign unused_cfg_mask = ^cfg_mask;
`endif

    prot_pal_match #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_match (
        .tbl  (tbl_q),
        .din  (din_q),
        .mode (mode_q),
        .hit  (hit),
        .idx  (unused_hit_idx),
        .ent  (hit_ent)
    );

    // Lookup reads tbl_q, so a coincident cfg write only affects later events
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q      <= 1'b1;
            ev_q      <= 1'b0;
            din_q     <= '0;
            resp_q    <= '0;
            mode_q    <= '0;
            hit_cnt_q <= '0;
            miss_q    <= 1'b0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i] <= default_entry(i);
            end
        end else begin
            wr_q   <= wr_n;
            ev_q   <= event_d;
            miss_q <= ev_q & ~hit;
            if (event_d) begin
                din_q <= din;
            end
            if (ev_q && hit) begin
                resp_q <= hit_ent.resp;
                if (hit_ent.set) begin
                    mode_q <= hit_ent.next;
                end
                if (hit_cnt_q != 8'hff) begin
                    hit_cnt_q <= hit_cnt_q + 8'd1;
                end
            end
            for (int i = 0; i < int'(ENTRIES); i++) begin
                if (cfg_we && (cfg_addr == AW'(i))) begin
                    tbl_q[i] <= cfg_ent;
                end
            end
        end
    end

    assign dout    = resp_q & OUT_MASK;
    assign mode    = mode_q;
    assign hit_cnt = hit_cnt_q;
    assign miss    = miss_q;

endmodule

// File: tb/tb_prot_pal_seq.sv
// Directed bench for prot_pal_seq; expected values are hand-derived from the
// default table and dout = resp & 8'h7e.
module tb_prot_pal_seq;

    logic       clk;
    logic       reset_n;
    logic       wr_n;
    logic       gate;
    logic [7:0] din;
    logic [7:0] dout;
    logic [0:0] mode;
    logic [7:0] hit_cnt;
    logic       miss;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_key;
    logic [7:0] cfg_mask;
    logic [7:0] cfg_resp;
    logic [0:0] cfg_mode;
    logic       cfg_any;
    logic       cfg_set;
    logic [0:0] cfg_next;
    logic       cfg_valid;

    int n_checks = 0;
    int n_pass   = 0;

    prot_pal_seq u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_n      (wr_n),
        .gate      (gate),
        .din       (din),
        .dout      (dout),
        .mode      (mode),
        .hit_cnt   (hit_cnt),
        .miss      (miss),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_key   (cfg_key),
        .cfg_mask  (cfg_mask),
        .cfg_resp  (cfg_resp),
        .cfg_mode  (cfg_mode),
        .cfg_any   (cfg_any),
        .cfg_set   (cfg_set),
        .cfg_next  (cfg_next),
        .cfg_valid (cfg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Falling edge on wr_n, then back high; returns on the negedge after stage 2
    task automatic pulse(input logic [7:0] d, input logic g);
        @(negedge clk);
        din  = d;
        gate = g;
        wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [2:0] addr, input logic [7:0] key, input logic [7:0] msk,
                           input logic [7:0] resp, input logic any);
        cfg_addr  = addr;
        cfg_key   = key;
        cfg_mask  = msk;
        cfg_resp  = resp;
        cfg_mode  = 1'b0;
        cfg_any   = any;
        cfg_set   = 1'b0;
        cfg_next  = 1'b0;
        cfg_valid = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_n    = 1'b1;
        gate    = 1'b1;
        din     = 8'h00;
        cfg_we  = 1'b0;
        set_cfg(3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_mode", mode, 1'b0);
        check("rst_hits", hit_cnt, 8'd0);
        check("rst_miss", miss, 1'b0);

        pulse(8'ha5, 1'b1);
        check("a5_dout", dout, 8'h40);
        check("a5_hits", hit_cnt, 8'd1);
        check("a5_mode", mode, 1'b0);

        pulse(8'hcd, 1'b1);
        check("cd_dout", dout, 8'h16);
        check("cd_mode", mode, 1'b0);
        pulse(8'h36, 1'b1);
        check("36_m0_dout", dout, 8'h7a);
        pulse(8'h6f, 1'b1);
        check("6f_m0_dout", dout, 8'h3e);

        pulse(8'hc2, 1'b1);
        check("c2_mode", mode, 1'b1);
        check("c2_dout", dout, 8'h4c);
        pulse(8'h36, 1'b1);
        check("36_m1_dout", dout, 8'h2a);
        pulse(8'h6f, 1'b1);
        check("6f_m1_dout", dout, 8'h66);

        pulse(8'ha5, 1'b0);
        check("gate0_dout", dout, 8'h66);
        check("gate0_hits", hit_cnt, 8'd7);
        check("gate0_miss", miss, 1'b0);

        // Gate rises while wr_n is already low: no event
        @(negedge clk);
        din  = 8'ha5;
        gate = 1'b0;
        wr_n = 1'b0;
        @(negedge clk);
        gate = 1'b1;
        repeat (2) @(negedge clk);
        wr_n = 1'b1;
        repeat (2) @(negedge clk);
        check("late_gate_dout", dout, 8'h66);
        check("late_gate_hits", hit_cnt, 8'd7);

        pulse(8'h00, 1'b1);
        check("nomatch_miss", miss, 1'b1);
        check("nomatch_dout", dout, 8'h66);
        check("nomatch_hits", hit_cnt, 8'd7);
        @(negedge clk);
        check("miss_one_cycle", miss, 1'b0);

        // Table write coincident with the stage-2 lookup of an a5 event
        @(negedge clk);
        din  = 8'ha5;
        gate = 1'b1;
        wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        set_cfg(3'd0, 8'ha5, 8'hff, 8'h55, 1'b1);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_old_dout", dout, 8'h40);
        pulse(8'ha5, 1'b1);
        check("cfg_new_dout", dout, 8'h54);
        check("cfg_hits", hit_cnt, 8'd9);

        @(negedge clk);
        set_cfg(3'd7, 8'ha0, 8'hf0, 8'h10, 1'b1);
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        pulse(8'ha3, 1'b1);
`ifdef PROT_PAL_MASK_EN
        check("mask_dout", dout, 8'h10);
        check("mask_miss", miss, 1'b0);
`else
        check("exact_dout", dout, 8'h54);
        check("exact_miss", miss, 1'b1);
`endif

        // Reset lands on the stage-2 cycle of a c2 event
        @(negedge clk);
        din  = 8'hc2;
        gate = 1'b1;
        wr_n = 1'b0;
        @(negedge clk);
        wr_n    = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_dout", dout, 8'h00);
        check("midrst_mode", mode, 1'b0);
        check("midrst_hits", hit_cnt, 8'd0);
        repeat (2) @(negedge clk);
        check("midrst_late_dout", dout, 8'h00);
        check("midrst_late_hits", hit_cnt, 8'd0);
        pulse(8'ha5, 1'b1);
        check("midrst_table_dout", dout, 8'h40);

        for (int i = 0; i < 260; i++) begin
            pulse(8'ha5, 1'b1);
        end
        check("hits_saturate", hit_cnt, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
